// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM.
// States, opcodes, datapath select codes and the control word bundle.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    WB_ALU   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    WB_MEM   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] WBS_ALU = 2'd0;
  localparam logic [1:0] WBS_MEM = 2'd1;
  localparam logic [1:0] WBS_PC  = 2'd2;

  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_RS1   = 2'd1;
  localparam logic [1:0] A_OLDPC = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_CMP   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  typedef struct packed {
    logic       mem_en;
    logic       mem_wr;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic state_t decode_next(
    input logic [6:0] opc,
    input logic [2:0] f3
  );
    state_t n;
    unique case (1'b1)
      opc == OPC_R:      n = EXEC_R;
      opc == OPC_I:      n = EXEC_I;
      opc == OPC_LOAD,
      opc == OPC_STORE:  n = MEM_ADDR;
      opc == OPC_BRANCH: n = BRANCH;
      opc == OPC_JAL:    n = JAL;
      opc == OPC_JALR:   n = (f3 == 3'b000) ? JALR : HALT;
      default:           n = HALT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the FSM (master) and the datapath (slave).
// Carries IR fields, ALU flags, memory ready and every select/strobe.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero;
  logic       alu_lt;
  logic       alu_ltu;
  logic       mem_ready;
  logic       mem_en;
  logic       mem_wr;
  logic       iord;
  logic       ir_we;
  logic       pc_we;
  logic       pc_src;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic [1:0] alu_a_sel;
  logic [1:0] alu_b_sel;
  logic [1:0] alu_op;

  modport master (
    input  opcode, funct3,
    input  alu_zero, alu_lt, alu_ltu,
    input  mem_ready,
    output mem_en, mem_wr, iord,
    output ir_we, pc_we, pc_src, rf_we,
    output wb_sel, alu_a_sel,
    output alu_b_sel, alu_op
  );

  modport slave (
    output opcode, funct3,
    output alu_zero, alu_lt, alu_ltu,
    output mem_ready,
    input  mem_en, mem_wr, iord,
    input  ir_we, pc_we, pc_src, rf_we,
    input  wb_sel, alu_a_sel,
    input  alu_b_sel, alu_op
  );
endinterface

// File: rtl/multicycle_ctrl_branch_cond.sv
// Branch outcome from funct3 and ALU compare flags.
// funct3 010/011 are not branches and are flagged as bad.
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       take,
  output logic       bad_funct3
);
  always_comb begin
    take       = 1'b0;
    bad_funct3 = 1'b0;
    unique case (funct3)
      3'b000: take = alu_zero;
      3'b001: take = !alu_zero;
      3'b100: take = alu_lt;
      3'b101: take = !alu_lt;
      3'b110: take = alu_ltu;
      3'b111: take = !alu_ltu;
      3'b010,
      3'b011: bad_funct3 = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Define PERF_CNT_EN to build the cycle/instret counters.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus,
  output logic             halted,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam bit TO_EN = MEM_TIMEOUT > 0;
  localparam logic [31:0] TO_LAST =
    TO_EN ? 32'(MEM_TIMEOUT - 1) : 32'd0;

  state_t      state;
  state_t      nxt;
  ctrl_t       c;
  ctrl_t       cq;
  logic [31:0] wait_cnt;
  logic        take;
  logic        bad_f3;
  logic        mem_st;
  logic        tmo;

  branch_cond u_br (
    .funct3     (bus.funct3),
    .alu_zero   (bus.alu_zero),
    .alu_lt     (bus.alu_lt),
    .alu_ltu    (bus.alu_ltu),
    .take       (take),
    .bad_funct3 (bad_f3)
  );

  assign mem_st = state inside {FETCH, MEM_RD, MEM_WR};
  assign tmo    = TO_EN && mem_st && !bus.mem_ready
                  && (wait_cnt == TO_LAST);

  always_comb begin
    c   = '0;
    nxt = state;
    unique case (state)
      FETCH: begin
        c.mem_en    = 1'b1;
        c.alu_b_sel = B_FOUR;
        if (bus.mem_ready) begin
          c.ir_we = 1'b1;
          c.pc_we = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        c.alu_a_sel = A_OLDPC;
        c.alu_b_sel = B_IMM;
        nxt = decode_next(bus.opcode, bus.funct3);
      end
      EXEC_R: begin
        c.alu_a_sel = A_RS1;
        c.alu_b_sel = B_RS2;
        c.alu_op    = ALU_FUNCT;
        nxt         = WB_ALU;
      end
      EXEC_I: begin
        c.alu_a_sel = A_RS1;
        c.alu_b_sel = B_IMM;
        c.alu_op    = ALU_FUNCT;
        nxt         = WB_ALU;
      end
      WB_ALU: begin
        c.rf_we  = 1'b1;
        c.wb_sel = WBS_ALU;
        nxt      = FETCH;
      end
      MEM_ADDR: begin
        c.alu_a_sel = A_RS1;
        c.alu_b_sel = B_IMM;
        nxt = (bus.opcode == OPC_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        c.mem_en = 1'b1;
        c.iord   = 1'b1;
        if (bus.mem_ready) nxt = WB_MEM;
      end
      WB_MEM: begin
        c.rf_we  = 1'b1;
        c.wb_sel = WBS_MEM;
        nxt      = FETCH;
      end
      MEM_WR: begin
        c.mem_en = 1'b1;
        c.mem_wr = 1'b1;
        c.iord   = 1'b1;
        if (bus.mem_ready) nxt = FETCH;
      end
      BRANCH: begin
        c.alu_a_sel = A_RS1;
        c.alu_b_sel = B_RS2;
        c.alu_op    = ALU_CMP;
        c.pc_src    = 1'b1;
        c.pc_we     = take;
        nxt         = bad_f3 ? HALT : FETCH;
      end
      JAL: begin
        c.rf_we  = 1'b1;
        c.wb_sel = WBS_PC;
        c.pc_we  = 1'b1;
        c.pc_src = 1'b1;
        nxt      = FETCH;
      end
      JALR: begin
        c.alu_a_sel = A_RS1;
        c.alu_b_sel = B_IMM;
        c.rf_we     = 1'b1;
        c.wb_sel    = WBS_PC;
        c.pc_we     = 1'b1;
        nxt         = FETCH;
      end
      HALT:    nxt = HALT;
      default: nxt = HALT;
    endcase
    if (tmo) nxt = HALT;
  end

  // Any state change restarts the memory wait count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= nxt;
      wait_cnt <= (nxt != state) ? 32'd0
                                 : wait_cnt + 32'd1;
    end
  end

  assign cq            = rst ? '0 : c;
  assign bus.mem_en    = cq.mem_en;
  assign bus.mem_wr    = cq.mem_wr;
  assign bus.iord      = cq.iord;
  assign bus.ir_we     = cq.ir_we;
  assign bus.pc_we     = cq.pc_we;
  assign bus.pc_src    = cq.pc_src;
  assign bus.rf_we     = cq.rf_we;
  assign bus.wb_sel    = cq.wb_sel;
  assign bus.alu_a_sel = cq.alu_a_sel;
  assign bus.alu_b_sel = cq.alu_b_sel;
  assign bus.alu_op    = cq.alu_op;
  assign halted        = !rst && (state == HALT);
  assign state_out     = state;

`ifdef PERF_CNT_EN
  logic retire;
  assign retire = (nxt == FETCH) && (state inside
    {WB_ALU, WB_MEM, MEM_WR, BRANCH, JAL, JALR});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded
// into its expected per-cycle step list and every cycle is compared.
module tb_multicycle_ctrl;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    int st;
    bit rdy;
  } cyc_t;

  logic        clk;
  logic        rst;
  logic        halted;
  logic [3:0]  state_out;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic [14:0] dut_w;

  int   n_chk;
  int   n_err;
  int   ncyc;
  int   ninst;
  bit   rand_flags;
  cyc_t seq[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .MEM_TIMEOUT (5),
    .CNT_W       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .halted      (halted),
    .state_out   (state_out),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  assign dut_w = {bus.mem_en, bus.mem_wr, bus.iord, bus.ir_we,
                  bus.pc_we, bus.pc_src, bus.rf_we, bus.wb_sel,
                  bus.alu_a_sel, bus.alu_b_sel, bus.alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit br_take(logic [2:0] f3, bit z, bit lt,
                                 bit ltu);
    bit base;
    if (f3[2:1] == 2'b01) return 1'b0;
    base = !f3[2] ? z : (f3[1] ? ltu : lt);
    return base ^ f3[0];
  endfunction

  // Expected control word {mem_en,mem_wr,iord,ir_we,pc_we,pc_src,
  // rf_we,wb_sel,a_sel,b_sel,alu_op} for one step.
  function automatic logic [14:0] exp_word(int st, bit rdy, bit tk);
    bit me, mw, io, ir, pw, ps, rw;
    logic [1:0] wb, a, b, op;
    {me, mw, io, ir, pw, ps, rw} = 7'd0;
    {wb, a, b, op} = 8'd0;
    case (st)
      0: begin me = 1; b = 2; ir = rdy; pw = rdy; end
      1: begin a = 2; b = 1; end
      2: begin a = 1; b = 0; op = 2; end
      3: begin a = 1; b = 1; op = 2; end
      4: rw = 1;
      5: begin a = 1; b = 1; end
      6: begin me = 1; io = 1; end
      7: begin rw = 1; wb = 1; end
      8: begin me = 1; mw = 1; io = 1; end
      9: begin a = 1; op = 1; ps = 1; pw = tk; end
      10: begin rw = 1; wb = 2; pw = 1; ps = 1; end
      11: begin a = 1; b = 1; rw = 1; wb = 2; pw = 1; end
      default: ;
    endcase
    return {me, mw, io, ir, pw, ps, rw, wb, a, b, op};
  endfunction

  function automatic void push(int st);
    seq.push_back('{st, 1'($urandom)});
  endfunction

  // Memory wait of d idle cycles; d >= 5 runs into the timeout.
  function automatic bit push_wait(int st, int d);
    for (int i = 0; i < d && i < 5; i++) seq.push_back('{st, 1'b0});
    if (d >= 5) return 1'b1;
    seq.push_back('{st, 1'b1});
    return 1'b0;
  endfunction

  task automatic build(input logic [6:0] opc, input logic [2:0] f3,
                       input int df, input int dm,
                       output bit ret, output bit hlt);
    seq.delete();
    ret = 1'b0;
    hlt = 1'b0;
    if (push_wait(0, df)) begin
      hlt = 1'b1;
      return;
    end
    push(1);
    case (opc)
      7'b0110011: begin push(2); push(4); ret = 1; end
      7'b0010011: begin push(3); push(4); ret = 1; end
      7'b0000011: begin
        push(5);
        if (push_wait(6, dm)) hlt = 1;
        else begin push(7); ret = 1; end
      end
      7'b0100011: begin
        push(5);
        if (push_wait(8, dm)) hlt = 1;
        else ret = 1;
      end
      7'b1100011: begin
        push(9);
        if (f3 == 3'd2 || f3 == 3'd3) hlt = 1;
        else ret = 1;
      end
      7'b1101111: begin push(10); ret = 1; end
      7'b1100111: begin
        if (f3 == 3'd0) begin push(11); ret = 1; end
        else hlt = 1;
      end
      default: hlt = 1;
    endcase
  endtask

  task automatic step(input cyc_t c);
    bit tk;
    bus.mem_ready = c.rdy;
    if (rand_flags) begin
      bus.alu_zero = 1'($urandom);
      bus.alu_lt   = 1'($urandom);
      bus.alu_ltu  = 1'($urandom);
    end
    tk = br_take(bus.funct3, bus.alu_zero, bus.alu_lt, bus.alu_ltu);
    @(negedge clk);
    chk($sformatf("state@%0d", c.st), 32'(state_out), 32'(c.st));
    chk($sformatf("ctrl@%0d", c.st), 32'(dut_w),
        32'(exp_word(c.st, c.rdy, tk)));
    chk("halted", 32'(halted), 32'(c.st == 12));
    chk("cycle_cnt", cycle_cnt, PERF ? 32'(ncyc) : 32'd0);
    chk("instret_cnt", instret_cnt, PERF ? 32'(ninst) : 32'd0);
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_ctrl"}, 32'(dut_w), 32'd0);
    chk({tag, "_state"}, 32'(state_out), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_cyc"}, cycle_cnt, 32'd0);
    chk({tag, "_inst"}, instret_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ncyc  = 0;
    ninst = 0;
  endtask

  task automatic run(input logic [6:0] opc, input logic [2:0] f3,
                     input int df, input int dm, input int nh);
    bit ret, hlt;
    bus.opcode = opc;
    bus.funct3 = f3;
    build(opc, f3, df, dm, ret, hlt);
    foreach (seq[i]) step(seq[i]);
    if (ret) ninst++;
    if (hlt) begin
      repeat (nh) step('{12, 1'($urandom)});
      do_reset("rst_halt");
    end
  endtask

  initial begin
    bit ret, hlt;
    int k, idx;
    logic [6:0] opc;
    n_chk = 0;
    n_err = 0;
    ncyc  = 0;
    ninst = 0;
    rand_flags    = 1'b1;
    rst           = 1'b1;
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.alu_zero  = 1'b0;
    bus.alu_lt    = 1'b0;
    bus.alu_ltu   = 1'b0;
    bus.mem_ready = 1'b1;
    #2;
    chk("init_ctrl", 32'(dut_w), 32'd0);
    chk("init_state", 32'(state_out), 32'd0);
    chk("init_halted", 32'(halted), 32'd0);
    chk("init_cyc", cycle_cnt, 32'd0);
    chk("init_inst", instret_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(7'b0110011, 3'd0, 0, 0, 0);
    run(7'b0000011, 3'd2, 0, 3, 0);
    rand_flags   = 1'b0;
    bus.alu_zero = 1'b1;
    run(7'b1100011, 3'd0, 0, 0, 0);
    bus.alu_zero = 1'b0;
    run(7'b1100011, 3'd0, 0, 0, 0);
    rand_flags = 1'b1;
    run(7'b0000000, 3'd0, 0, 0, 20);
    run(7'b0100011, 3'd2, 0, 5, 3);
    run(7'b0100011, 3'd2, 0, 4, 0);
    run(7'b0110011, 3'd0, 5, 0, 2);
    run(7'b1100011, 3'd2, 1, 0, 2);
    run(7'b1100111, 3'd1, 0, 0, 2);
    run(7'b1101111, 3'd0, 4, 0, 0);
    run(7'b1100111, 3'd0, 0, 0, 0);

    // Reset lands in the middle of a store wait.
    bus.opcode = 7'b0100011;
    bus.funct3 = 3'd2;
    build(7'b0100011, 3'd2, 0, 5, ret, hlt);
    idx = 0;
    while (seq[idx].st != 8) begin
      step(seq[idx]);
      idx++;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("wr_pre", 32'(bus.mem_wr), 32'd1);
    do_reset("rst_mid_wr");

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: opc = 7'b0110011;
        1: opc = 7'b0010011;
        2: opc = 7'b0000011;
        3: opc = 7'b0100011;
        4: opc = 7'b1100011;
        5: opc = 7'b1101111;
        6, 7: opc = 7'b1100111;
        default: opc = 7'($urandom);
      endcase
      run(opc, 3'($urandom),
          ($urandom_range(0, 31) == 0) ? 5 : $urandom_range(0, 4),
          ($urandom_range(0, 15) == 0) ? 5 : $urandom_range(0, 4),
          $urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
